// File: rtl/arb3_pkg.sv
// Shared types for the three-requester memory arbiter: FSM states and grant-select codes.
package arb3_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [1:0] SEL_0 = 2'b00;
  localparam logic [1:0] SEL_1 = 2'b01;
  localparam logic [1:0] SEL_2 = 2'b10;

endpackage

// File: rtl/mux3.sv
// Three-way select for one requester field; select code 11 is never produced and falls to input 2.
module mux3 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_d2;
    case (i_sel)
      2'b00:   o_y = i_d0;
      2'b01:   o_y = i_d1;
      default: o_y = i_d2;
    endcase
  end

endmodule

// File: rtl/mem_arb3.sv
// Round-robin arbiter sharing one memory port among three requesters.
// One arbitration cycle in IDLE, then BUSY until the memory signals ready.
module mem_arb3
  import arb3_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  input  logic          we0,
  input  logic          we1,
  input  logic          we2,
  output logic [2:0]    done,
  output logic [DW-1:0] rdata,
  output logic [1:0]    sel,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  // Search starts one past the last completed requester, wrapping mod 3.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] pick;
    pick = last;
    case (last)
      SEL_0:   pick = req[1] ? SEL_1 : (req[2] ? SEL_2 : SEL_0);
      SEL_1:   pick = req[2] ? SEL_2 : (req[0] ? SEL_0 : SEL_1);
      default: pick = req[0] ? SEL_0 : (req[1] ? SEL_1 : SEL_2);
    endcase
    return pick;
  endfunction

  state_e     r_state, w_state_d;
  logic [1:0] r_sel, w_sel_d;
  logic [1:0] r_last, w_last_d;
  logic [2:0] w_req;
  logic [2:0] w_done;
  logic       w_busy;
  logic [0:0] w_we_sel;

  assign w_req = {req2, req1, req0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= SEL_0;
      r_last  <= SEL_2;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_last  <= w_last_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_last_d  = r_last;
    w_done    = 3'b000;
    w_busy    = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_sel_d   = rr_pick(r_last, w_req);
          w_state_d = BUSY;
        end
      end
      BUSY: begin
        w_busy = 1'b1;
        if (mem_ready) begin
          w_done    = 3'b001 << r_sel;
          w_last_d  = r_sel;
          w_state_d = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  mux3 #(.WIDTH(AW)) u_mux_addr (
    .i_sel (r_sel),
    .i_d0  (addr0),
    .i_d1  (addr1),
    .i_d2  (addr2),
    .o_y   (mem_addr)
  );

  mux3 #(.WIDTH(DW)) u_mux_wdata (
    .i_sel (r_sel),
    .i_d0  (wdata0),
    .i_d1  (wdata1),
    .i_d2  (wdata2),
    .o_y   (mem_wdata)
  );

  mux3 #(.WIDTH(1)) u_mux_we (
    .i_sel (r_sel),
    .i_d0  (we0),
    .i_d1  (we1),
    .i_d2  (we2),
    .o_y   (w_we_sel)
  );

  // Reset abandons an in-flight access: no request, no completion while it is asserted.
  assign mem_req = w_busy & ~reset;
  assign mem_we  = w_busy & ~reset & w_we_sel[0];
  assign done    = reset ? 3'b000 : w_done;
  assign rdata   = mem_rdata;
  assign sel     = r_sel;

endmodule
